rr_arbiter8: RTL and testbench

Round-robin arbiter that sits directly upstream of the 8-to-3 encoder. It accepts eight request lines and issues a registered one-hot grant vector, which the encoder turns into a 3-bit index. Each grant is held until the requester releases it or a hold-time limit expires. Fairness comes from a rotating priority pointer.

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_pick8.sv | 29 ++
 rtl/rr_arbiter8.sv | 114 +++++++++++
 tb/tb_rr_arbiter8.sv | 122 ++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter; no logic, no latency.
// Priority pointer arithmetic wraps modulo N_REQ.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        return IDX_W'(idx + IDX_W'(1));
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request at or after ptr, as one-hot.
// Zero latency; no flow control, found is low when no request is set.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic             found
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [2*N_REQ-1:0] rot_dbl;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   rot_first;
    logic [2*N_REQ-1:0] back_dbl;

    // Rotate right so index ptr lands at bit 0, isolate lowest set bit, rotate back.
    always_comb begin
        req_dbl   = {req, req};
        rot_dbl   = req_dbl >> ptr;
        rot       = rot_dbl[N_REQ-1:0];
        rot_first = rot & (~rot + N_REQ'(1));
        back_dbl  = {rot_first, rot_first} << ptr;
        pick      = back_dbl[2*N_REQ-1:N_REQ];
        found     = |req;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with registered one-hot grant, done/req-drop release and hold limit.
// Grant one cycle after request; one idle bubble after every release.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic             v,
    output logic             timeout
);

    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CW-1:0]    hold_q, hold_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             v_q, v_d;
    logic             to_q, to_d;

    logic [N_REQ-1:0] pick;
    logic             found;
    logic [IDX_W-1:0] pick_idx;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .pick  (pick),
        .found (found)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) pick_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (en && found) begin
                    gnt_d   = pick;
                    idx_d   = pick_idx;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!en) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end else if (done || !req[idx_q]) begin
                    gnt_d   = '0;
                    ptr_d   = rr_next(idx_q);
                    state_d = IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    gnt_d   = '0;
                    to_d    = 1'b1;
                    ptr_d   = rr_next(idx_q);
                    state_d = IDLE;
                end else begin
                    // Below HOLD_LAST here, so the increment never wraps.
                    hold_d = hold_q + CW'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        v_d = |gnt_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            v_q     <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            v_q     <= v_d;
            to_q    <= to_d;
        end
    end

    assign gnt     = gnt_q;
    assign v       = v_q;
    assign timeout = to_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 (MAX_HOLD=4) with a queue of expected per-cycle outputs.
module tb_rr_arbiter8;

    typedef struct packed {
        logic [7:0] gnt;
        logic       v;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       v;
    logic       timeout;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .v       (v),
        .timeout (timeout)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
    task automatic step(input string tag, input logic r, input logic e, input logic [7:0] rq,
                        input logic d, input logic [7:0] eg, input logic et);
        exp_t x;
        rst  = r;
        en   = e;
        req  = rq;
        done = d;
        x.gnt = eg;
        x.v   = |eg;
        x.to  = et;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        check({tag, ".gnt"}, gnt, x.gnt);
        check({tag, ".v"}, {7'd0, v}, {7'd0, x.v});
        check({tag, ".timeout"}, {7'd0, timeout}, {7'd0, x.to});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b0; req = '0; done = 1'b0;
        @(posedge clk);
        #1;
        step("reset", 1, 0, 8'h00, 0, 8'h00, 0);
        step("en_low_idle", 0, 0, 8'hFF, 0, 8'h00, 0);

        // Basic grant, release by done, pointer advance.
        step("t1_grant0", 0, 1, 8'h05, 0, 8'h01, 0);
        step("t1_done0", 0, 1, 8'h05, 1, 8'h00, 0);
        step("t1_grant2", 0, 1, 8'h05, 0, 8'h04, 0);
        step("t1_done2", 0, 1, 8'h05, 1, 8'h00, 0);

        // Full rotation with all requesters active.
        step("t2_reset", 1, 1, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 9; i++) begin
            step("t2_grant", 0, 1, 8'hFF, 0, 8'h01 << (i % 8), 0);
            step("t2_bubble", 0, 1, 8'hFF, 1, 8'h00, 0);
        end

        // Hold limit: four grant cycles, then timeout pulse in the bubble.
        step("t3_grant", 0, 1, 8'h10, 0, 8'h10, 0);
        step("t3_hold1", 0, 1, 8'h10, 0, 8'h10, 0);
        step("t3_hold2", 0, 1, 8'h10, 0, 8'h10, 0);
        step("t3_hold3", 0, 1, 8'h10, 0, 8'h10, 0);
        step("t3_revoke", 0, 1, 8'h10, 0, 8'h00, 1);
        step("t3_regrant", 0, 1, 8'h10, 0, 8'h10, 0);

        // done on the hold-limit cycle wins over timeout.
        step("t4_hold1", 0, 1, 8'h10, 0, 8'h10, 0);
        step("t4_hold2", 0, 1, 8'h10, 0, 8'h10, 0);
        step("t4_hold3", 0, 1, 8'h10, 0, 8'h10, 0);
        step("t4_done_at_limit", 0, 1, 8'h10, 1, 8'h00, 0);

        // en drop keeps ptr (5): 0C then picks bit 2, not bit 3.
        step("t5_grant2", 0, 1, 8'h04, 0, 8'h04, 0);
        step("t5_en_drop", 0, 0, 8'h04, 0, 8'h00, 0);
        step("t5_regrant2", 0, 1, 8'h0C, 0, 8'h04, 0);
        step("t5_req_drop", 0, 1, 8'h08, 0, 8'h00, 0);

        // ptr=3 so 81 picks bit 7; reset at the hold limit gives no timeout and ptr=0.
        step("t6_grant7", 0, 1, 8'h81, 0, 8'h80, 0);
        step("t6_hold1", 0, 1, 8'h81, 0, 8'h80, 0);
        step("t6_hold2", 0, 1, 8'h81, 0, 8'h80, 0);
        step("t6_hold3", 0, 1, 8'h81, 0, 8'h80, 0);
        step("t6_rst", 1, 1, 8'h81, 0, 8'h00, 0);
        step("t6_grant0", 0, 1, 8'h81, 0, 8'h01, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
